// File: rtl/mem_port_arbiter_pkg.sv
// Shared state and owner encodings for the unified-memory port arbiter.
// Used by the arbiter RTL; holds no logic of its own.
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Fetch/load-store arbiter for one single-ported memory: data wins unless fetch has starved STARVE_MAX grants.
// Grant is same-cycle, valid returns MEM_LAT cycles later; losers backpressure by holding req until their gnt.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    output logic          stall_if,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_valid,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int LCW = $clog2(MEM_LAT + 1);
    localparam int SCW = $clog2(STARVE_MAX + 1);
    localparam logic [LCW-1:0] LAT_INIT   = LCW'(MEM_LAT);
    localparam logic [LCW-1:0] LAT_ONE    = LCW'(1);
    localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);
    localparam logic [SCW-1:0] STARVE_ONE = SCW'(1);

    arb_state_e     state_q,      state_d;
    arb_owner_e     owner_q,      owner_d;
    logic [LCW-1:0] lat_cnt_q,    lat_cnt_d;
    logic [SCW-1:0] starve_cnt_q, starve_cnt_d;

    logic done;
    logic grant_ok;
    logic pick_if;

    // Outputs are forced low while rst_n is asserted so the port looks dead during reset.
    always_comb begin
        done     = rst_n && (state_q == BUSY) && (lat_cnt_q == LAT_ONE);
        grant_ok = rst_n && ((state_q == IDLE) || done);
        pick_if  = if_req && ((starve_cnt_q == STARVE_TOP) || !dm_req);

        if_gnt   = grant_ok && pick_if;
        dm_gnt   = grant_ok && dm_req && !pick_if;

        if_valid = done && (owner_q == OWN_IF);
        dm_valid = done && (owner_q == OWN_DM);
        if_rdata = if_valid ? mem_rdata : '0;
        dm_rdata = dm_valid ? mem_rdata : '0;
        stall_if = rst_n && if_req && !if_valid;

        mem_en    = if_gnt || dm_gnt;
        mem_we    = dm_gnt && dm_we;
        mem_addr  = if_gnt ? if_addr : (dm_gnt ? dm_addr : '0);
        mem_wdata = mem_we ? dm_wdata : '0;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;

        if (mem_en) begin
            state_d   = BUSY;
            lat_cnt_d = LAT_INIT;
            owner_d   = if_gnt ? OWN_IF : OWN_DM;
        end else if (state_q == BUSY) begin
            lat_cnt_d = lat_cnt_q - LAT_ONE;
            if (done) begin
                state_d = IDLE;
            end
        end

        // Counts data wins only while fetch is actually waiting.
        if (if_gnt || !if_req) begin
            starve_cnt_d = '0;
        end else if (dm_gnt && (starve_cnt_q != STARVE_TOP)) begin
            starve_cnt_d = starve_cnt_q + STARVE_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    a_if_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (if_req && !if_gnt) |=> if_req);
    a_dm_req_held: assert property (@(posedge clk) disable iff (!rst_n)
        (dm_req && !dm_gnt) |=> dm_req);

    if (MEM_LAT > 1) begin : g_en_gap
        a_en_gap: assert property (@(posedge clk) disable iff (!rst_n)
            mem_en |=> !mem_en);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
// Expected completions are queued at grant time and retired when the valid pulse is due.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
    logic        if_gnt, if_valid, stall_if, dm_gnt, dm_valid, mem_en, mem_we;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    logic        if_req1 = 1'b0;
    logic [31:0] if_addr1 = '0, mem_rdata1 = '0;
    logic        if_gnt1, if_valid1, stall_if1, dm_gnt1, dm_valid1, mem_en1, mem_we1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;

    typedef struct {
        bit is_if;
        bit chk_rd;
        int due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .if_rdata(if_rdata), .stall_if(stall_if),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_valid(if_valid1),
        .if_rdata(if_rdata1), .stall_if(stall_if1),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
        .dm_gnt(dm_gnt1), .dm_valid(dm_valid1), .dm_rdata(dm_rdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock of stimulus on the MEM_LAT=2 instance with the expected grant outcome.
    task automatic step(input logic rs, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dd, input logic eig, input logic edg);
        logic        exp_iv;
        logic        exp_dv;
        logic        exp_rd;
        logic [31:0] rd_val;
        @(negedge clk);
        rd_val    = 32'hC0DE_0000 + 32'(cyc);
        rst_n     = rs;
        if_req    = ir;
        if_addr   = ia;
        dm_req    = dr;
        dm_we     = dw;
        dm_addr   = da;
        dm_wdata  = dd;
        mem_rdata = rd_val;
        #1;
        exp_iv = 1'b0;
        exp_dv = 1'b0;
        exp_rd = 1'b0;
        if (!rs) begin
            sb.delete();
        end else if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_iv = sb[0].is_if;
            exp_dv = !sb[0].is_if;
            exp_rd = sb[0].chk_rd;
            void'(sb.pop_front());
        end

        chk("if_gnt",   {31'b0, if_gnt},   {31'b0, eig});
        chk("dm_gnt",   {31'b0, dm_gnt},   {31'b0, edg});
        chk("mem_en",   {31'b0, mem_en},   {31'b0, eig | edg});
        chk("if_valid", {31'b0, if_valid}, {31'b0, exp_iv});
        chk("dm_valid", {31'b0, dm_valid}, {31'b0, exp_dv});
        chk("stall_if", {31'b0, stall_if}, {31'b0, rs & ir & ~exp_iv});

        if (exp_iv) chk("if_rdata", if_rdata, rd_val);
        if (exp_dv && exp_rd) chk("dm_rdata", dm_rdata, rd_val);

        if (eig) begin
            chk("if_mem_addr", mem_addr, ia);
            chk("if_mem_we", {31'b0, mem_we}, 32'd0);
            sb.push_back('{is_if: 1'b1, chk_rd: 1'b1, due: cyc + LAT});
        end
        if (edg) begin
            chk("dm_mem_addr", mem_addr, da);
            chk("dm_mem_we", {31'b0, mem_we}, {31'b0, dw});
            if (dw) chk("dm_mem_wdata", mem_wdata, dd);
            sb.push_back('{is_if: 1'b0, chk_rd: !dw, due: cyc + LAT});
        end
        if (!rs) begin
            chk("rst_mem_we",    {31'b0, mem_we}, 32'd0);
            chk("rst_mem_addr",  mem_addr,  32'd0);
            chk("rst_mem_wdata", mem_wdata, 32'd0);
            chk("rst_if_rdata",  if_rdata,  32'd0);
            chk("rst_dm_rdata",  dm_rdata,  32'd0);
        end
        cyc++;
    endtask

    initial begin
        // Reset, including requests presented while reset is held.
        step(0, 0, 32'h0,   0, 0, 32'h0,    32'h0, 0, 0);
        step(0, 0, 32'h0,   0, 0, 32'h0,    32'h0, 0, 0);
        step(0, 1, 32'h100, 1, 0, 32'h2000, 32'h0, 0, 0);
        step(1, 0, 32'h0,   0, 0, 32'h0,    32'h0, 0, 0);

        // Fetch stream with PC held while pending.
        step(1, 1, 32'h100, 0, 0, 32'h0, 32'h0, 1, 0);
        step(1, 1, 32'h104, 0, 0, 32'h0, 32'h0, 0, 0);
        step(1, 1, 32'h104, 0, 0, 32'h0, 32'h0, 1, 0);
        step(1, 1, 32'h108, 0, 0, 32'h0, 32'h0, 0, 0);
        step(1, 1, 32'h108, 0, 0, 32'h0, 32'h0, 1, 0);
        step(1, 0, 32'h0,   0, 0, 32'h0, 32'h0, 0, 0);
        step(1, 0, 32'h0,   0, 0, 32'h0, 32'h0, 0, 0);

        // Collision: load wins, fetch follows back-to-back.
        step(1, 1, 32'h10C, 1, 0, 32'h2000, 32'h0, 0, 1);
        step(1, 1, 32'h10C, 0, 0, 32'h0,    32'h0, 0, 0);
        step(1, 1, 32'h10C, 0, 0, 32'h0,    32'h0, 1, 0);
        step(1, 0, 32'h0,   0, 0, 32'h0,    32'h0, 0, 0);
        step(1, 0, 32'h0,   0, 0, 32'h0,    32'h0, 0, 0);

        // Store and its ack.
        step(1, 0, 32'h0, 1, 1, 32'h40, 32'hDEADBEEF, 0, 1);
        step(1, 0, 32'h0, 0, 0, 32'h0,  32'h0,        0, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0,  32'h0,        0, 0);

        // Starvation: four data grants then a forced fetch grant.
        for (int k = 0; k < 5; k++) begin
            int dn;
            dn = (k < 4) ? k + 1 : 4;
            step(1, 1, 32'h200, 1, 0, 32'h3000 + 32'(k * 4), 32'h0, k == 4, k != 4);
            step(1, k != 4, 32'h200, 1, 0, 32'h3000 + 32'(dn * 4), 32'h0, 0, 0);
        end
        step(1, 0, 32'h0, 1, 0, 32'h3010, 32'h0, 0, 1);
        step(1, 0, 32'h0, 0, 0, 32'h0,    32'h0, 0, 0);
        step(1, 0, 32'h0, 0, 0, 32'h0,    32'h0, 0, 0);

        // Reset while an access is in flight.
        step(1, 1, 32'h300, 0, 0, 32'h0,   32'h0, 1, 0);
        step(0, 0, 32'h0,   0, 0, 32'h0,   32'h0, 0, 0);
        step(1, 0, 32'h0,   0, 0, 32'h0,   32'h0, 0, 0);
        step(1, 0, 32'h0,   1, 0, 32'h500, 32'h0, 0, 1);
        step(1, 0, 32'h0,   0, 0, 32'h0,   32'h0, 0, 0);
        step(1, 0, 32'h0,   0, 0, 32'h0,   32'h0, 0, 0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // MEM_LAT=1: one fetch granted every cycle.
        for (int i = 0; i < 6; i++) begin
            logic [31:0] rd1;
            @(negedge clk);
            rd1        = 32'hBEEF_0000 + 32'(i);
            if_req1    = 1'b1;
            if_addr1   = 32'h400 + 32'(i * 4);
            mem_rdata1 = rd1;
            #1;
            chk("l1_if_gnt",   {31'b0, if_gnt1},   32'd1);
            chk("l1_mem_en",   {31'b0, mem_en1},   32'd1);
            chk("l1_mem_addr", mem_addr1, 32'h400 + 32'(i * 4));
            chk("l1_if_valid", {31'b0, if_valid1}, (i > 0) ? 32'd1 : 32'd0);
            chk("l1_stall_if", {31'b0, stall_if1}, (i == 0) ? 32'd1 : 32'd0);
            if (i > 0) chk("l1_if_rdata", if_rdata1, rd1);
            chk("l1_dm_valid", {31'b0, dm_valid1}, 32'd0);
        end
        @(negedge clk);
        if_req1 = 1'b0;
        #1;
        chk("l1_tail_gnt",   {31'b0, if_gnt1},   32'd0);
        chk("l1_tail_en",    {31'b0, mem_en1},   32'd0);
        chk("l1_tail_valid", {31'b0, if_valid1}, 32'd1);
        @(negedge clk);
        #1;
        chk("l1_idle_valid", {31'b0, if_valid1}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
